// File: rtl/dmem_pkg.sv
// Shared address map and FSM state type for the data-memory subsystem.
package dmem_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] IO_BASE    = 32'h1000_0000;
  localparam logic [31:0] LED_ADDR   = IO_BASE;
  localparam logic [31:0] SW_ADDR    = IO_BASE + 32'h4;
  localparam logic [31:0] TIMER_ADDR = IO_BASE + 32'h8;

  typedef enum logic [0:0] {
    IDLE,
    RD_WAIT
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous read; contents are never reset.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_subsystem.sv
// Data memory: RAM with one-cycle load stall, LED/switch registers and a timer.
// The timer register exists only when DMEM_TIMER_EN is defined.
module dmem_subsystem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LED_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             memwrite_i,
  input  logic             memread_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      writedata_i,
  input  logic [LED_W-1:0] sw_i,
  output logic [31:0]      readdata_o,
  output logic             stall_o,
  output logic             misaligned_o,
  output logic [LED_W-1:0] led_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e           r_state;
  state_e           w_state_d;
  logic [LED_W-1:0] r_led;
  logic [31:0]      w_io_data;
  logic [31:0]      w_ram_rdata;
  logic             w_aligned;
  logic             w_in_ram;
  logic             w_rd;
  logic             w_wr;
  logic             w_ram_load;
  logic             w_ram_re;

  assign w_aligned  = (addr_i[1:0] == 2'b00);
  assign w_in_ram   = (((addr_i - RAM_BASE) >> (AW + 2)) == 32'd0);
  // A simultaneous store wins over the load.
  assign w_rd       = memread_i & ~memwrite_i & w_aligned;
  assign w_wr       = memwrite_i & w_aligned;
  assign w_ram_load = w_rd & w_in_ram;

  dmem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (w_wr & w_in_ram),
    .re_i   (w_ram_re),
    .addr_i (addr_i[AW+1:2]),
    .wdata_i(writedata_i),
    .rdata_o(w_ram_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_ram_load) w_state_d = RD_WAIT;
      RD_WAIT: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if the CPU still requests.
  always_comb begin
    stall_o    = 1'b0;
    w_ram_re   = 1'b0;
    readdata_o = 32'd0;
    unique case (r_state)
      IDLE: begin
        w_ram_re = w_ram_load;
        stall_o  = w_ram_load & ~reset_i;
        if (w_rd && !w_in_ram && !reset_i) readdata_o = w_io_data;
      end
      RD_WAIT: if (!reset_i) readdata_o = w_ram_rdata;
      default: ;
    endcase
  end

  assign misaligned_o = ~reset_i & (memread_i | memwrite_i) & ~w_aligned;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                         r_led <= '0;
    else if (w_wr && addr_i == LED_ADDR) r_led <= writedata_i[LED_W-1:0];
  end

  assign led_o = r_led;

`ifdef DMEM_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                           r_timer <= 32'd0;
    else if (w_wr && addr_i == TIMER_ADDR) r_timer <= writedata_i;
    else                                   r_timer <= r_timer + 32'd1;
  end
`endif

  always_comb begin
    w_io_data = 32'd0;
    if (addr_i == LED_ADDR)     w_io_data = 32'(r_led);
    else if (addr_i == SW_ADDR) w_io_data = 32'(sw_i);
`ifdef DMEM_TIMER_EN
    else if (addr_i == TIMER_ADDR) w_io_data = r_timer;
`endif
  end

endmodule

// File: tb/tb_dmem_subsystem.sv
// Bench for dmem_subsystem: directed table, corner sequences, random vs. a transaction model.
module tb_dmem_subsystem;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LED_W = 16;
  localparam logic [31:0] LED   = 32'h1000_0000;
  localparam logic [31:0] SW    = 32'h1000_0004;
  localparam logic [31:0] TMR   = 32'h1000_0008;
`ifdef DMEM_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_i = 1'b0;
  logic             memwrite_i = 1'b0;
  logic             memread_i = 1'b0;
  logic [31:0]      addr_i = '0;
  logic [31:0]      writedata_i = '0;
  logic [LED_W-1:0] sw_i = '0;
  logic [31:0]      readdata_o;
  logic             stall_o;
  logic             misaligned_o;
  logic [LED_W-1:0] led_o;

  int n_vec = 0;
  int n_err = 0;

  dmem_subsystem #(
    .DEPTH(DEPTH),
    .LED_W(LED_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .memwrite_i  (memwrite_i),
    .memread_i   (memread_i),
    .addr_i      (addr_i),
    .writedata_i (writedata_i),
    .sw_i        (sw_i),
    .readdata_o  (readdata_o),
    .stall_o     (stall_o),
    .misaligned_o(misaligned_o),
    .led_o       (led_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a pending RAM load is captured at the request edge.
  logic [31:0]      m_ram [DEPTH];
  logic             m_wait;
  logic [31:0]      m_pend;
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_timer;

  function automatic bit in_ram(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_wait  <= 1'b0;
      m_led   <= '0;
      m_timer <= '0;
    end else begin
      m_wait  <= !m_wait && memread_i && !memwrite_i && addr_i[1:0] == 0 && in_ram(addr_i);
      m_pend  <= in_ram(addr_i) ? m_ram[addr_i >> 2] : 32'd0;
      m_timer <= m_timer + 1;
      if (memwrite_i && addr_i[1:0] == 0) begin
        if (in_ram(addr_i))     m_ram[addr_i >> 2] <= writedata_i;
        else if (addr_i == LED) m_led <= writedata_i[LED_W-1:0];
        else if (addr_i == TMR) m_timer <= writedata_i;
      end
    end
  end

  task automatic model_out(output logic [31:0] rd, output logic st, output logic mis);
    rd  = 32'd0;
    st  = 1'b0;
    mis = 1'b0;
    if (!reset_i) begin
      mis = (memread_i || memwrite_i) && addr_i[1:0] != 0;
      if (m_wait) rd = m_pend;
      else if (memread_i && !memwrite_i && addr_i[1:0] == 0) begin
        if (in_ram(addr_i))     st = 1'b1;
        else if (addr_i == LED) rd = 32'(m_led);
        else if (addr_i == SW)  rd = 32'(sw_i);
        else if (addr_i == TMR) rd = TIMER_ON ? m_timer : 32'd0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [LED_W-1:0] s);
    @(posedge clk);
    #1;
    memwrite_i  = wr;
    memread_i   = rd;
    addr_i      = a;
    writedata_i = wd;
    sw_i        = s;
  endtask

  typedef struct {
    logic             wr;
    logic             rd;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [LED_W-1:0] sw;
    logic [31:0]      e_rdata;
    logic             e_stall;
    logic             e_mis;
    logic [LED_W-1:0] e_led;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic [LED_W-1:0] s, input logic [31:0] er, input logic es,
                     input logic em, input logic [LED_W-1:0] el);
    vec_t v;
    v = '{wr, rd, a, wd, s, er, es, em, el};
    tbl.push_back(v);
  endtask

  logic [31:0] picks [14] = '{32'h0, 32'h4, 32'h6, 32'h10, 32'h11, 32'h20, 32'hFFC, 32'h1000,
                              LED, SW, TMR, 32'h1000_000C, 32'h1000_0001, 32'h2000_0000};

  initial begin
    logic [31:0] e_rd;
    logic        e_st;
    logic        e_mis;
    //   wr rd addr            wdata         sw       rdata         st mis led
    add(1, 0, 32'h10,          32'hDEADBEEF, 16'h0,   32'h0,        0, 0, 16'h0);
    add(0, 1, 32'h10,          32'h0,        16'h0,   32'h0,        1, 0, 16'h0);
    add(0, 1, 32'h10,          32'h0,        16'h0,   32'hDEADBEEF, 0, 0, 16'h0);
    add(1, 0, LED,             32'h00A5,     16'h0,   32'h0,        0, 0, 16'h0);
    add(0, 1, SW,              32'h0,        16'h1234, 32'h1234,    0, 0, 16'hA5);
    add(1, 0, 32'h4,           32'h55,       16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h6,           32'h0,        16'h0,   32'h0,        0, 1, 16'hA5);
    add(1, 0, 32'h6,           32'hFFFFFFFF, 16'h0,   32'h0,        0, 1, 16'hA5);
    add(0, 1, 32'h4,           32'h0,        16'h0,   32'h0,        1, 0, 16'hA5);
    add(0, 1, 32'h4,           32'h0,        16'h0,   32'h55,       0, 0, 16'hA5);
    add(1, 1, 32'h20,          32'h11,       16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h20,          32'h0,        16'h0,   32'h0,        1, 0, 16'hA5);
    add(0, 1, 32'h20,          32'h0,        16'h0,   32'h11,       0, 0, 16'hA5);
    add(1, 0, 32'h0,           32'h77,       16'h0,   32'h0,        0, 0, 16'hA5);
    add(1, 0, 32'hFFC,         32'hCAFEF00D, 16'h0,   32'h0,        0, 0, 16'hA5);
    add(1, 0, 32'h1000,        32'h99,       16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h1000,        32'h0,        16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h0,           32'h0,        16'h0,   32'h0,        1, 0, 16'hA5);
    add(0, 1, 32'h0,           32'h0,        16'h0,   32'h77,       0, 0, 16'hA5);
    add(0, 1, 32'hFFC,         32'h0,        16'h0,   32'h0,        1, 0, 16'hA5);
    add(0, 1, 32'hFFC,         32'h0,        16'h0,   32'hCAFEF00D, 0, 0, 16'hA5);
    add(0, 1, LED,             32'h0,        16'h0,   32'hA5,       0, 0, 16'hA5);
    add(1, 0, 32'h1000_0001,   32'hFFFF,     16'h0,   32'h0,        0, 1, 16'hA5);
    add(0, 1, LED,             32'h0,        16'h0,   32'hA5,       0, 0, 16'hA5);
    add(1, 0, 32'h2000_0000,   32'h1234,     16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h2000_0000,   32'h0,        16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, 32'h1000_000C,   32'h0,        16'h0,   32'h0,        0, 0, 16'hA5);
    add(1, 0, LED,             32'hFFFF5A5A, 16'h0,   32'h0,        0, 0, 16'hA5);
    add(0, 1, LED,             32'h0,        16'h0,   32'h5A5A,     0, 0, 16'h5A5A);
    add(0, 0, LED,             32'h0,        16'h0,   32'h0,        0, 0, 16'h5A5A);
    add(0, 1, SW,              32'h0,        16'hFFFF, 32'hFFFF,    0, 0, 16'h5A5A);

    // Reset values while reset is held.
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdata", readdata_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_mis", 32'(misaligned_o), 32'h0);
    chk("rst_led", 32'(led_o), 32'h0);
    reset_i   = 1'b0;
    memread_i = 1'b1;
    addr_i    = TMR;
    #1;
    chk("rst_timer", readdata_o, 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].sw);
      @(negedge clk);
      chk($sformatf("tbl%0d_rdata", i), readdata_o, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_stall", i), 32'(stall_o), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_mis", i), 32'(misaligned_o), 32'(tbl[i].e_mis));
      chk($sformatf("tbl%0d_led", i), 32'(led_o), 32'(tbl[i].e_led));
    end

    // Reset during RD_WAIT with the load still requested.
    drive(0, 1, 32'h10, 0, 0);
    @(negedge clk);
    chk("rw_req_stall", 32'(stall_o), 32'h1);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    #1;
    chk("rw_rst_stall", 32'(stall_o), 32'h0);
    chk("rw_rst_rdata", readdata_o, 32'h0);
    chk("rw_rst_led", 32'(led_o), 32'h0);
    memread_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    drive(0, 1, 32'h10, 0, 0);
    @(negedge clk);
    chk("rw_post_stall", 32'(stall_o), 32'h1);
    @(negedge clk);
    chk("rw_post_rdata", readdata_o, 32'hDEADBEEF);
    chk("rw_post_stall2", 32'(stall_o), 32'h0);

    // Timer wrap after a store.
    drive(1, 0, TMR, 32'hFFFF_FFFE, 0);
    drive(0, 1, TMR, 0, 0);
    @(negedge clk);
    chk("tmr0", readdata_o, TIMER_ON ? 32'hFFFF_FFFE : 32'h0);
    drive(0, 1, TMR, 0, 0);
    @(negedge clk);
    chk("tmr1", readdata_o, TIMER_ON ? 32'hFFFF_FFFF : 32'h0);
    drive(0, 1, TMR, 0, 0);
    @(negedge clk);
    chk("tmr2", readdata_o, 32'h0);
    chk("tmr_stall", 32'(stall_o), 32'h0);

    // Back-to-back RAM loads stall each time.
    drive(0, 1, 32'h20, 0, 0);
    @(negedge clk);
    chk("b2b_st0", 32'(stall_o), 32'h1);
    @(negedge clk);
    chk("b2b_d0", readdata_o, 32'h11);
    drive(0, 1, 32'h0, 0, 0);
    @(negedge clk);
    chk("b2b_st1", 32'(stall_o), 32'h1);
    chk("b2b_rd1", readdata_o, 32'h0);
    @(negedge clk);
    chk("b2b_d1", readdata_o, 32'h77);
    chk("b2b_st1b", 32'(stall_o), 32'h0);

    // Random traffic; inputs are held while a RAM load is outstanding.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      sw_i = LED_W'($urandom);
      if (!m_wait) begin
        int op;
        op          = int'($urandom_range(0, 9));
        addr_i      = picks[$urandom_range(0, 13)];
        writedata_i = $urandom;
        memread_i   = (op <= 3) || (op == 7);
        memwrite_i  = (op >= 4) && (op <= 7);
      end
      @(negedge clk);
      model_out(e_rd, e_st, e_mis);
      chk("rnd_rdata", readdata_o, e_rd);
      chk("rnd_stall", 32'(stall_o), 32'(e_st));
      chk("rnd_mis", 32'(misaligned_o), 32'(e_mis));
      chk("rnd_led", 32'(led_o), 32'(m_led));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_subsystem.md
# dmem_subsystem

Data-memory subsystem directly downstream of the single-cycle datapath. It consumes the ALU result as the address, the register-file rs2 value as store data, and the memwrite/memread controls. It returns load data to the datapath's result mux. It contains a synchronous-read word RAM, memory-mapped LED/switch registers and an optional free-running timer, and raises a one-cycle stall on RAM loads.

## Interface
- DEPTH, 1024, RAM size in 32-bit words (power of two)
- LED_W, 16, width of LED output register and switch input
- clk_i  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-high reset
- memwrite_i  in  1  store request this cycle
- memread_i  in  1  load request this cycle
- addr_i  in  32  byte address (datapath ALU result)
- writedata_i  in  32  store data (datapath rs2)
- sw_i  in  LED_W  board switches, sampled combinationally
- readdata_o  out  32  load data to the datapath result mux
- stall_o  out  1  high: CPU must hold PC and instruction this cycle
- misaligned_o  out  1  high: current access has addr_i[1:0] != 0 and is suppressed
- led_o  out  LED_W  LED register contents

## Operation
- Address map (word accesses only):
  - RAM at 0x0000_0000 .. DEPTH*4-1.
  - LED at 0x1000_0000 (RW, low LED_W bits).
  - SW at 0x1000_0004 (RO, zero-extended).
  - TIMER at 0x1000_0008 (RW).
- Unmapped address: reads return 0; writes are ignored.
- FSM states: IDLE, RD_WAIT.
- IDLE:
  - A RAM load (memread_i=1, memwrite_i=0, aligned, RAM range) drives stall_o=1 combinationally.
  - The RAM read is issued at the clock edge, and the FSM goes to RD_WAIT.
- RD_WAIT:
  - readdata_o = RAM output, stall_o=0.
  - The FSM always returns to IDLE at the next edge, even if memread_i is still high.
  - The held instruction therefore completes exactly once.
- Peripheral loads and unmapped loads are combinational. They do not stall and do not leave IDLE.
- Stores write at the rising edge of the cycle in which memwrite_i=1. They never stall.
- memwrite_i and memread_i both high: the store wins, no read and no stall, readdata_o=0.
- Misaligned access: misaligned_o=1 in the same cycle, the access is suppressed, readdata_o=0, no stall.
- readdata_o is 0 whenever no valid load data is being presented.
- TIMER:
  - 32-bit counter, increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - A store to TIMER loads writedata_i in place of the increment, so it reads back exactly the written value next cycle.
- RAM contents are not initialised or reset.

## Timing
- Reset values:
  - state IDLE, stall_o 0, misaligned_o 0, readdata_o 0.
  - led_o 0, TIMER 0.
- RAM load latency: 2 cycles (request cycle stalled + data cycle). Peripheral load latency: 0 cycles.
- Store latency: visible to a load issued in the following cycle.
- stall_o depends combinationally on state, memread_i, memwrite_i and addr_i. It is not registered.
- Reset asserted in RD_WAIT: return to IDLE asynchronously with stall_o=0. The pending read is discarded.
- Back-to-back RAM loads: IDLE, RD_WAIT, IDLE, RD_WAIT. The second load stalls again.

## Configuration
- DMEM_TIMER_EN defined: TIMER counter and register are present as described.
- Not defined:
  - No counter flops are synthesised.
  - Reads of 0x1000_0008 return 0 and writes are ignored, as for an unmapped address.

## Structure
- Package dmem_pkg holds:
  - address constants (RAM_BASE, LED_ADDR, SW_ADDR, TIMER_ADDR, IO_BASE);
  - the FSM state enum (IDLE, RD_WAIT).
- Sub-module dmem_ram: single-port, synchronous-read, word-addressed RAM.
  - Parameter DEPTH.
  - Ports: clk_i, we_i, re_i, addr_i[$clog2(DEPTH)-1:0], wdata_i, rdata_o.
  - Not reset.
- Top level holds the decode, FSM, peripheral registers and read mux.

## Test plan
- Store 0xDEADBEEF to 0x10, then load 0x10: stall_o=1 for one cycle, then readdata_o=0xDEADBEEF with stall_o=0.
- Store 0x00A5 to 0x1000_0000 -> led_o=0x00A5 next cycle. sw_i=0x1234, load 0x1000_0004 -> readdata_o=0x0000_1234 same cycle, no stall.
- Load from 0x0000_0006 -> misaligned_o=1, readdata_o=0, stall_o=0, RAM unchanged.
- With DMEM_TIMER_EN defined:
  - Store 0xFFFF_FFFE to TIMER, then load TIMER on consecutive cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
  - Without the macro, the same reads return 0.
- Assert reset_i mid-RD_WAIT -> stall_o=0, state IDLE, led_o=0 immediately. After release, a load of a previously stored RAM word still returns its value.
- memwrite_i=memread_i=1 at 0x20 with data 0x11 -> no stall, readdata_o=0. A subsequent load returns 0x11.
